// File: rtl/uart_pkg.sv
// Shared defaults and helpers for the UART baud-tick generator.
package uart_pkg;

  localparam int DEF_DIV_W      = 16;
  localparam int DEF_FRAC_W     = 4;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int OS_W           = $clog2(DEF_OVERSAMPLE);

  // Integer clocks per oversample tick; the fractional remainder is dropped.
  function automatic int default_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable UART baud-tick generator: oversampled rx_tick plus bit-rate tx_tick from one divisor counter.
// Optional fractional divisor accumulator is built only when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int FRAC_W     = DEF_FRAC_W
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          rx_sync,
  output logic                          rx_tick,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          div_err
);

  localparam int               PH_W      = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(default_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_shadow;
  logic [PH_W-1:0]  r_os_phase;
  logic             r_rx_tick;
  logic             r_tx_tick;
  logic             r_div_err;

  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_wrap;
  logic [DIV_W-1:0] w_div_shadow_nxt;
  logic [DIV_W:0]   w_cnt_inc;
  logic [DIV_W:0]   w_period;

  assign w_load_ok        = div_load && (div_int >= DIV_MIN);
  assign w_load_bad       = div_load && (div_int < DIV_MIN);
  // A load in the same cycle as a boundary or sync takes effect at that boundary.
  assign w_div_shadow_nxt = w_load_ok ? div_int : r_div_shadow;
  assign w_cnt_inc        = {1'b0, r_cnt} + (DIV_W+1)'(1);
  assign w_wrap           = en && (w_cnt_inc == w_period);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_frac_act;
  logic [FRAC_W-1:0] r_frac_shadow;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extra;
  logic [FRAC_W-1:0] w_frac_shadow_nxt;
  logic [FRAC_W:0]   w_acc_sum;

  assign w_frac_shadow_nxt = w_load_ok ? div_frac : r_frac_shadow;
  assign w_acc_sum         = {1'b0, r_acc} + {1'b0, r_frac_act};
  // A carry out of the accumulator stretches the following period by one clock.
  assign w_period          = {1'b0, r_div_act} + {{DIV_W{1'b0}}, r_extra};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frac_act    <= '0;
      r_frac_shadow <= '0;
      r_acc         <= '0;
      r_extra       <= 1'b0;
    end else begin
      r_frac_shadow <= w_frac_shadow_nxt;
      if (rx_sync) begin
        r_frac_act <= w_frac_shadow_nxt;
        r_acc      <= '0;
        r_extra    <= 1'b0;
      end else if (w_wrap) begin
        r_frac_act <= w_frac_shadow_nxt;
        r_acc      <= w_acc_sum[FRAC_W-1:0];
        r_extra    <= w_acc_sum[FRAC_W];
      end
    end
  end
`else
  logic w_unused_frac;

  assign w_unused_frac = ^div_frac;
  assign w_period      = {1'b0, r_div_act};
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_shadow <= DIV_RESET;
      r_div_err    <= 1'b0;
    end else begin
      r_div_shadow <= w_div_shadow_nxt;
      r_div_err    <= w_load_bad;
    end
  end

  // Sync has priority over a wrap and ignores en so realignment is never lost.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div_act  <= DIV_RESET;
      r_os_phase <= '0;
      r_rx_tick  <= 1'b0;
      r_tx_tick  <= 1'b0;
    end else if (rx_sync) begin
      r_cnt      <= '0;
      r_div_act  <= w_div_shadow_nxt;
      r_os_phase <= PH_MID;
      r_rx_tick  <= 1'b0;
      r_tx_tick  <= 1'b0;
    end else if (w_wrap) begin
      r_cnt      <= '0;
      r_div_act  <= w_div_shadow_nxt;
      r_os_phase <= r_os_phase + PH_W'(1);
      r_rx_tick  <= 1'b1;
      r_tx_tick  <= (r_os_phase == PH_LAST);
    end else begin
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
      if (en) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign rx_tick  = r_rx_tick;
  assign tx_tick  = r_tx_tick;
  assign os_phase = r_os_phase;
  assign div_err  = r_div_err;

endmodule
